// File: rtl/dmem_mmio_target_pkg.sv
// Shared definitions for the data-memory / MMIO responder: MMIO register
// offsets, STATUS bit positions and the address-region selector.
package dmem_pkg;

  localparam logic [1:0] MMIO_COUNT  = 2'd0;
  localparam logic [1:0] MMIO_CMP    = 2'd1;
  localparam logic [1:0] MMIO_STATUS = 2'd2;
  localparam logic [1:0] MMIO_TXDATA = 2'd3;

  localparam int ST_IRQ   = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

endpackage

// File: rtl/dmem_mmio_target_if.sv
// Core-side load/store bus plus TX stream and timer interrupt of the
// data-memory responder.
interface dmem_mmio_target_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [3:0]  MemWriteByte;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        timer_irq;

  modport slave (
    input  MemWrite, Addr, WriteData, MemWriteByte, tx_ready,
    output ReadData, tx_valid, tx_data, timer_irq
  );

  modport master (
    output MemWrite, Addr, WriteData, MemWriteByte, tx_ready,
    input  ReadData, tx_valid, tx_data, timer_irq
  );
endinterface

// File: rtl/dmem_mmio_target_tx_fifo.sv
// Small byte FIFO with sticky overflow flag; pointers carry one extra bit so
// full and empty are told apart without a separate counter register.
module tx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       clr_ovf,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
  logic              ovf_q, ovf_d;
  logic              pop_ok, push_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  assign count = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (count == (PW+1)'(DEPTH));

  always_comb begin
    pop_ok  = pop & ~empty;
    // A push into a full FIFO is only accepted when a pop frees the slot.
    push_ok = push & (~full | pop_ok);
    wr_d    = wr_q + (PW+1)'(push_ok);
    rd_d    = rd_q + (PW+1)'(pop_ok);
    ovf_d   = (push & full & ~pop_ok) | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[PW-1:0]] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_q[PW-1:0]];
  assign overflow  = ovf_q;

endmodule

// File: rtl/dmem_mmio_target.sv
// Data-side memory responder: byte-lane data RAM, free-running timer with
// compare interrupt, and a TX byte FIFO behind a 16-byte MMIO window.
module dmem_mmio_target
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic                clk,
  input  logic                reset,
  dmem_mmio_target_if.slave   bus
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  region_e         region;
  logic [1:0]      offset;
  logic [AW-1:0]   ram_idx;
  logic [3:0][7:0] ram_mem [RAM_WORDS];

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;

  logic        ram_we, mmio_we;
  logic        wr_count, wr_cmp, wr_status, wr_txdata;
  logic        fifo_full, fifo_empty, fifo_ovf, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [7:0]  fifo_head;
  logic [31:0] status_word;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus.Addr[1:0];

  always_comb begin
    region = REG_NONE;
    if (bus.Addr[31:AW+2] == '0)                 region = REG_RAM;
    else if (bus.Addr[31:4] == MMIO_BASE[31:4])  region = REG_MMIO;
  end

  assign offset  = bus.Addr[3:2];
  assign ram_idx = bus.Addr[AW+1:2];

  // MMIO registers take full-word writes; any nonzero lane mask qualifies.
  always_comb begin
    ram_we    = bus.MemWrite && (region == REG_RAM);
    mmio_we   = bus.MemWrite && (bus.MemWriteByte != 4'b0) && (region == REG_MMIO);
    wr_count  = mmio_we && (offset == MMIO_COUNT);
    wr_cmp    = mmio_we && (offset == MMIO_CMP);
    wr_status = mmio_we && (offset == MMIO_STATUS);
    wr_txdata = mmio_we && (offset == MMIO_TXDATA);
  end

  always_comb begin
    count_d = wr_count ? bus.WriteData : count_q + 32'd1;
    cmp_d   = wr_cmp   ? bus.WriteData : cmp_q;
    // Compare against the registered count; a set in the same cycle as a clear wins.
    irq_d   = (count_q == cmp_q) | (irq_q & ~(wr_status & bus.WriteData[ST_IRQ]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.MemWriteByte[b]) ram_mem[ram_idx][b] <= bus.WriteData[8*b +: 8];
      end
    end
  end

  assign fifo_pop = ~fifo_empty & bus.tx_ready;

  tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_txdata),
    .push_data (bus.WriteData[7:0]),
    .pop       (fifo_pop),
    .clr_ovf   (wr_status & bus.WriteData[ST_OVF]),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  always_comb begin
    status_word             = '0;
    status_word[ST_IRQ]     = irq_q;
    status_word[ST_FULL]    = fifo_full;
    status_word[ST_EMPTY]   = fifo_empty;
    status_word[ST_OVF]     = fifo_ovf;
    status_word[ST_CNT +: 4] = 4'(fifo_count);
  end

  always_comb begin
    bus.ReadData = 32'h0;
    case (region)
      REG_RAM:  bus.ReadData = ram_mem[ram_idx];
      REG_MMIO: begin
        case (offset)
          MMIO_COUNT:  bus.ReadData = count_q;
          MMIO_CMP:    bus.ReadData = cmp_q;
          MMIO_STATUS: bus.ReadData = status_word;
          default:     bus.ReadData = 32'h0;
        endcase
      end
      default:  bus.ReadData = 32'h0;
    endcase
  end

  assign bus.tx_valid  = ~fifo_empty;
  assign bus.tx_data   = fifo_head;
  assign bus.timer_irq = irq_q;

endmodule

// File: tb/tb_dmem_mmio_target.sv
// Directed bench for dmem_mmio_target: RAM lanes, timer, FIFO, reset, unmapped.
module tb_dmem_mmio_target;

  localparam logic [31:0] A_COUNT  = 32'hFFFF_FF00;
  localparam logic [31:0] A_CMP    = 32'hFFFF_FF04;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF08;
  localparam logic [31:0] A_TX     = 32'hFFFF_FF0C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmem_mmio_target_if bus();

  dmem_mmio_target #(
    .RAM_WORDS  (256),
    .FIFO_DEPTH (4),
    .MMIO_BASE  (32'hFFFF_FF00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.Addr = a; bus.WriteData = d; bus.MemWriteByte = be; bus.MemWrite = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0; bus.MemWriteByte = 4'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.Addr = a;
    #1;
    d = bus.ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bus.MemWrite = 1'b0; bus.MemWriteByte = 4'b0; bus.Addr = A_COUNT;
    bus.WriteData = 32'h0; bus.tx_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", bus.tx_valid); end
    checks++; if (bus.timer_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", bus.timer_irq); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", bus.tx_data); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rst_count_held got %h want 0", bus.ReadData); end
    @(negedge clk) reset = 1'b1;
    load(A_CMP, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp got %h want ffffffff", r); end
    load(A_STATUS, r);
    checks++; if (r !== 32'h0000_0004) begin errors++; $display("FAIL rst_status got %h want 00000004", r); end
  endtask

  task automatic test_ram_bytes();
    logic [31:0] r;
    store(32'h10, 32'hAABB_CCDD, 4'b1111);
    store(32'h10, 32'h1122_3344, 4'b0010);
    load(32'h10, r);
    checks++; if (r !== 32'hAABB_33DD) begin errors++; $display("FAIL ram_lane1 got %h want aabb33dd", r); end
    store(32'h20, 32'h0102_0304, 4'b1111);
    store(32'h20, 32'hFF00_0000, 4'b1000);
    load(32'h20, r);
    checks++; if (r !== 32'hFF02_0304) begin errors++; $display("FAIL ram_lane3 got %h want ff020304", r); end
    store(32'h3FC, 32'h5566_7788, 4'b1111);
    load(32'h3FC, r);
    checks++; if (r !== 32'h5566_7788) begin errors++; $display("FAIL ram_top_word got %h want 55667788", r); end
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    store(32'h0, 32'hCAFE_F00D, 4'b1111);
    store(32'h8000_0000, 32'hDEAD_BEEF, 4'b1111);
    store(32'h0000_0400, 32'h1234_5678, 4'b1111);
    store(32'h8000_000C, 32'h0000_005A, 4'b1111);
    store(32'h8000_0004, 32'h0000_0007, 4'b1111);
    store(32'hFFFF_FE04, 32'h0000_0009, 4'b1111);
    load(32'h0, r);
    checks++; if (r !== 32'hCAFE_F00D) begin errors++; $display("FAIL unmapped_ram0 got %h want cafef00d", r); end
    load(32'h8000_0000, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", r); end
    load(32'h0000_0400, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ram_bound_read got %h want 0", r); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL unmapped_tx got %b want 0", bus.tx_valid); end
    load(A_CMP, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL unmapped_cmp got %h want ffffffff", r); end
  endtask

  task automatic test_timer();
    logic [31:0] r;
    bit found;
    store(A_COUNT, 32'd10, 4'b1111);
    store(A_CMP, 32'd20, 4'b0001);
    checks++; if (bus.timer_irq !== 1'b0) begin errors++; $display("FAIL irq_pre got %b want 0", bus.timer_irq); end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      load(A_COUNT, r);
      if (r == 32'd20) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL count_reach20 got %0d want 20", r); end
    checks++; if (bus.timer_irq !== 1'b0) begin errors++; $display("FAIL irq_at_match got %b want 0", bus.timer_irq); end
    @(posedge clk);
    #1;
    checks++; if (bus.timer_irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b want 1", bus.timer_irq); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.timer_irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", bus.timer_irq); end
    store(A_STATUS, 32'h1, 4'b1111);
    checks++; if (bus.timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", bus.timer_irq); end
    store(A_CMP, 32'd200, 4'b1111);
    store(A_COUNT, 32'd200, 4'b1111);
    checks++; if (bus.timer_irq !== 1'b0) begin errors++; $display("FAIL irq_before_tie got %b want 0", bus.timer_irq); end
    store(A_STATUS, 32'h1, 4'b1111);
    checks++; if (bus.timer_irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b want 1", bus.timer_irq); end
  endtask

  task automatic test_count_wrap();
    logic [31:0] r;
    store(A_COUNT, 32'hFFFF_FFFF, 4'b1111);
    load(A_COUNT, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_load_max got %h want ffffffff", r); end
    load(A_COUNT, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL count_wrap got %h want 0", r); end
    store(A_COUNT, 32'h1234_5678, 4'b0100);
    load(A_COUNT, r);
    checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL count_write_prio got %h want 12345678", r); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] r;
    logic [7:0] exp [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    bus.tx_ready = 1'b0;
    store(A_STATUS, 32'h9, 4'b1111);
    for (int i = 0; i < 5; i++) store(A_TX, 32'h41 + i, 4'b0001);
    load(A_STATUS, r);
    checks++; if (r !== 32'h0000_004A) begin errors++; $display("FAIL fifo_full_status got %h want 0000004a", r); end
    @(negedge clk);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i]) begin
        errors++; $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, bus.tx_valid, bus.tx_data, exp[i]);
      end
      @(negedge clk);
    end
    bus.tx_ready = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", bus.tx_valid); end
    load(A_STATUS, r);
    checks++; if (r !== 32'h0000_000C) begin errors++; $display("FAIL drain_status got %h want 0000000c", r); end
    store(A_STATUS, 32'h8, 4'b1111);
    load(A_STATUS, r);
    checks++; if (r !== 32'h0000_0004) begin errors++; $display("FAIL ovf_clear got %h want 00000004", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [7:0] exp [4] = '{8'h62, 8'h63, 8'h64, 8'h55};
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(A_TX, 32'h61 + i, 4'b1111);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    bus.Addr = A_TX; bus.WriteData = 32'h55; bus.MemWriteByte = 4'b1111; bus.MemWrite = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0; bus.MemWriteByte = 4'b0; bus.tx_ready = 1'b0;
    load(A_STATUS, r);
    checks++; if (r !== 32'h0000_0042) begin errors++; $display("FAIL pushpop_status got %h want 00000042", r); end
    @(negedge clk);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i]) begin
        errors++; $display("FAIL pushpop_drain_%0d got v=%b d=%h want v=1 d=%h", i, bus.tx_valid, bus.tx_data, exp[i]);
      end
      @(negedge clk);
    end
    bus.tx_ready = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty got %b want 0", bus.tx_valid); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    bus.tx_ready = 1'b0;
    store(A_CMP, 32'd1000, 4'b1111);
    store(A_COUNT, 32'd1000, 4'b1111);
    for (int i = 0; i < 3; i++) store(A_TX, 32'h70 + i, 4'b1111);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.timer_irq !== 1'b1) begin
      errors++; $display("FAIL pre_reset got v=%b irq=%b want v=1 irq=1", bus.tx_valid, bus.timer_irq);
    end
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.timer_irq !== 1'b0 || bus.tx_data !== 8'h00) begin
      errors++; $display("FAIL async_reset got v=%b irq=%b d=%h want 0 0 00", bus.tx_valid, bus.timer_irq, bus.tx_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.Addr = A_COUNT;
    #1;
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL post_rst_count got %h want 0", bus.ReadData); end
    load(A_CMP, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_rst_cmp got %h want ffffffff", r); end
    load(A_STATUS, r);
    checks++; if (r !== 32'h0000_0004) begin errors++; $display("FAIL post_rst_status got %h want 00000004", r); end
    load(A_COUNT, r);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL post_rst_count_run got %0d want 3", r); end
  endtask

  initial begin
    test_reset();
    test_ram_bytes();
    test_unmapped();
    test_timer();
    test_count_wrap();
    test_fifo_overflow();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
